// File: rtl/sort_pkg.sv
// Shared helpers for the rank sorter: index sizing and the key ordering rule
// used by every rank cell.
package sort_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++)
            if ((1 << k) < v) r = k + 1;
        return r;
    endfunction

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : clog2(n);
    endfunction

    // True when key a (at index ia) is placed before key b (at index ib).
    // Equal keys fall back to index order, which keeps the sort stable.
    function automatic logic key_precedes(input logic [31:0] a, input logic [31:0] b,
                                          input int ia, input int ib, input logic desc);
        if (a == b) return (ia < ib);
        return desc ? (a > b) : (a < b);
    endfunction

endpackage

// File: rtl/sort_rank_cell.sv
// Rank of element I within the vector: how many other keys precede it.
module sort_rank_cell
    import sort_pkg::*;
#(
    parameter int N    = 32,
    parameter int W    = 8,
    parameter int IDXW = idx_width(N),
    parameter int I    = 0
) (
    input  logic [N-1:0][W-1:0] i_keys,
    input  logic                i_desc,
    output logic [IDXW-1:0]     o_rank
);

    logic [N-1:0] w_hit;

    always_comb begin
        w_hit = '0;
        for (int j = 0; j < N; j++)
            if (j != I)
                w_hit[j] = key_precedes(32'(i_keys[j]), 32'(i_keys[I]), j, I, i_desc);
    end

    // Popcount of the hit vector; at most N-1 so it fits in IDXW bits.
    always_comb begin
        o_rank = '0;
        for (int j = 0; j < N; j++)
            o_rank = o_rank + IDXW'(w_hit[j]);
    end

endmodule

// File: rtl/sort_rank_pipe.sv
// Three-stage pipelined rank sorter: capture, rank, scatter. Each stage
// stalls independently so backpressure fills the pipe without loss.
module sort_rank_pipe
    import sort_pkg::*;
#(
    parameter int N    = 32,
    parameter int W    = 8,
    parameter int IDXW = idx_width(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*W-1:0]    in_data,
    input  logic              in_desc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*W-1:0]    out_data,
    output logic [N*IDXW-1:0] out_idx,
    output logic              out_desc
);

    logic [2:0]                r_vld;
    logic [N-1:0][W-1:0]       r_key0;
    logic                      r_desc0;
    logic [N-1:0][W-1:0]       r_key1;
    logic [N-1:0][IDXW-1:0]    r_rank1;
    logic                      r_desc1;
    logic [N-1:0][W-1:0]       r_odata;
    logic [N-1:0][IDXW-1:0]    r_oidx;
    logic                      r_odesc;

    logic [N-1:0][W-1:0]       w_in_key;
    logic [N-1:0][IDXW-1:0]    w_rank;
    logic [N-1:0][W-1:0]       w_sdata;
    logic [N-1:0][IDXW-1:0]    w_sidx;
    logic                      w_rdy1;
    logic                      w_rdy2;

    assign w_in_key = in_data;

    // Ready ripples back from the output; in_valid never feeds in_ready.
    assign w_rdy2   = !r_vld[2] || out_ready;
    assign w_rdy1   = !r_vld[1] || w_rdy2;
    assign in_ready = !r_vld[0] || w_rdy1;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_rank
            sort_rank_cell #(.N(N), .W(W), .IDXW(IDXW), .I(g)) u_cell (
                .i_keys (r_key0),
                .i_desc (r_desc0),
                .o_rank (w_rank[g])
            );
        end
    endgenerate

    // Ranks are a permutation, so exactly one element matches each slot and
    // a plain AND-OR mux needs no priority.
    always_comb begin
        w_sdata = '0;
        w_sidx  = '0;
        for (int s = 0; s < N; s++)
            for (int i = 0; i < N; i++)
                if (r_rank1[i] == IDXW'(s)) begin
                    w_sdata[s] = w_sdata[s] | r_key1[i];
                    w_sidx[s]  = w_sidx[s]  | IDXW'(i);
                end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld   <= '0;
            r_key0  <= '0;
            r_desc0 <= 1'b0;
            r_key1  <= '0;
            r_rank1 <= '0;
            r_desc1 <= 1'b0;
            r_odata <= '0;
            r_oidx  <= '0;
            r_odesc <= 1'b0;
        end else begin
            if (in_ready) begin
                r_vld[0] <= in_valid;
                if (in_valid) begin
                    r_key0  <= w_in_key;
                    r_desc0 <= in_desc;
                end
            end
            if (w_rdy1) begin
                r_vld[1] <= r_vld[0];
                if (r_vld[0]) begin
                    r_key1  <= r_key0;
                    r_rank1 <= w_rank;
                    r_desc1 <= r_desc0;
                end
            end
            if (w_rdy2) begin
                r_vld[2] <= r_vld[1];
                if (r_vld[1]) begin
                    r_odata <= w_sdata;
                    r_oidx  <= w_sidx;
                    r_odesc <= r_desc1;
                end
            end
        end
    end

    assign out_valid = r_vld[2];
    assign out_data  = r_odata;
    assign out_idx   = r_oidx;
    assign out_desc  = r_odesc;

endmodule

// File: tb/tb_sort_rank_pipe.sv
// Directed and randomized checks of sort_rank_pipe at N=32/W=8 and N=4/W=3
// against a stable insertion-sort reference model.
module tb_sort_rank_pipe;

    localparam int N    = 32;
    localparam int W    = 8;
    localparam int IDXW = 5;
    localparam int NS   = 4;
    localparam int WS   = 3;
    localparam int IXS  = 2;

    typedef struct packed {
        logic [N*W-1:0]    d;
        logic [N*IDXW-1:0] ix;
        logic              dsc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic              in_valid = 1'b0, in_ready, in_desc = 1'b0;
    logic [N*W-1:0]    in_data = '0;
    logic              out_valid, out_ready = 1'b1, out_desc;
    logic [N*W-1:0]    out_data;
    logic [N*IDXW-1:0] out_idx;

    logic               s_in_valid = 1'b0, s_in_ready, s_in_desc = 1'b0;
    logic [NS*WS-1:0]   s_in_data = '0;
    logic               s_out_valid, s_out_ready = 1'b1, s_out_desc;
    logic [NS*WS-1:0]   s_out_data;
    logic [NS*IXS-1:0]  s_out_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sort_rank_pipe #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_desc(in_desc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_desc(out_desc)
    );

    sort_rank_pipe #(.N(NS), .W(WS)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_desc(s_in_desc),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_idx(s_out_idx), .out_desc(s_out_desc)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stable insertion sort over source indices; equal keys never swap.
    function automatic exp_t ref_sort(input logic [N-1:0][W-1:0] k, input logic desc);
        int   ord[N];
        int   t;
        exp_t e;
        for (int i = 0; i < N; i++) ord[i] = i;
        for (int i = 1; i < N; i++)
            for (int j = i; j > 0; j--) begin
                if (desc ? (k[ord[j]] > k[ord[j-1]]) : (k[ord[j]] < k[ord[j-1]])) begin
                    t = ord[j]; ord[j] = ord[j-1]; ord[j-1] = t;
                end else break;
            end
        for (int s = 0; s < N; s++) begin
            e.d[s*W +: W]       = k[ord[s]];
            e.ix[s*IDXW +: IDXW] = IDXW'(ord[s]);
        end
        e.dsc = desc;
        return e;
    endfunction

    task automatic run_one(input logic [N-1:0][W-1:0] keys, input logic desc,
                           input logic [N*W-1:0] exp_d, input logic [N*IDXW-1:0] exp_ix,
                           input string tag);
        int c;
        @(negedge clk);
        in_valid = 1'b1; in_data = keys; in_desc = desc; out_ready = 1'b1;
        #1 chk({tag, "_in_ready"}, 256'(in_ready), 256'(1));
        @(negedge clk);
        in_valid = 1'b0; in_data = {N{8'hA5}}; in_desc = ~desc;
        c = 1;
        while (!out_valid && c < 10) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_latency"}, 256'(c), 256'(3));
        chk({tag, "_data"}, 256'(out_data), 256'(exp_d));
        chk({tag, "_idx"}, 256'(out_idx), 256'(exp_ix));
        chk({tag, "_desc"}, 256'(out_desc), 256'(desc));
        @(negedge clk);
    endtask

    task automatic run_small(input logic [NS-1:0][WS-1:0] keys,
                             input logic [NS*WS-1:0] exp_d, input logic [NS*IXS-1:0] exp_ix,
                             input string tag);
        int c;
        @(negedge clk);
        s_in_valid = 1'b1; s_in_data = keys; s_in_desc = 1'b0; s_out_ready = 1'b1;
        @(negedge clk);
        s_in_valid = 1'b0; s_in_data = '1;
        c = 1;
        while (!s_out_valid && c < 10) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_latency"}, 256'(c), 256'(3));
        chk({tag, "_data"}, 256'(s_out_data), 256'(exp_d));
        chk({tag, "_idx"}, 256'(s_out_idx), 256'(exp_ix));
        chk({tag, "_desc"}, 256'(s_out_desc), 256'(0));
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0][W-1:0]     keys;
        logic [N*W-1:0]          ed;
        logic [N*IDXW-1:0]       ei;
        logic [NS-1:0][WS-1:0]   skeys;
        logic [NS*WS-1:0]        sed;
        logic [NS*IXS-1:0]       sei;
        exp_t                    q[$];
        exp_t                    e;
        logic [N*W-1:0]          h_d;
        logic [N*IDXW-1:0]       h_ix;
        logic                    h_dsc, stalled;
        int                      sent, cyc;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_out_data", 256'(out_data), 256'(0));
        chk("rst_out_idx", 256'(out_idx), 256'(0));
        chk("rst_out_desc", 256'(out_desc), 256'(0));
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        chk("rst_s_in_ready", 256'(s_in_ready), 256'(1));

        // Reverse-ordered keys, ascending.
        for (int k = 0; k < N; k++) keys[k] = W'(N - 1 - k);
        for (int s = 0; s < N; s++) begin
            ed[s*W +: W] = W'(s); ei[s*IDXW +: IDXW] = IDXW'(N - 1 - s);
        end
        run_one(keys, 1'b0, ed, ei, "rev_asc");

        // Alternating 5/0: equal keys keep their input order.
        for (int k = 0; k < N; k++) keys[k] = (k % 2 == 0) ? W'(5) : W'(0);
        for (int s = 0; s < N; s++) begin
            ed[s*W +: W]         = (s < 16) ? W'(0) : W'(5);
            ei[s*IDXW +: IDXW]   = (s < 16) ? IDXW'(2*s + 1) : IDXW'(2*(s - 16));
        end
        run_one(keys, 1'b0, ed, ei, "stable");

        // Descending, keys k*3.
        for (int k = 0; k < N; k++) keys[k] = W'((k * 3) % 256);
        for (int s = 0; s < N; s++) begin
            ed[s*W +: W] = W'(3 * (N - 1 - s)); ei[s*IDXW +: IDXW] = IDXW'(N - 1 - s);
        end
        run_one(keys, 1'b1, ed, ei, "desc");

        // All keys equal at the maximum value: identity permutation.
        for (int k = 0; k < N; k++) keys[k] = '1;
        for (int s = 0; s < N; s++) begin
            ed[s*W +: W] = '1; ei[s*IDXW +: IDXW] = IDXW'(s);
        end
        run_one(keys, 1'b0, ed, ei, "all_ff");

        // Random traffic with random backpressure.
        sent = 0; cyc = 0; stalled = 1'b0;
        h_d = '0; h_ix = '0; h_dsc = 1'b0;
        while ((sent < 100 || q.size() != 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                chk("hold_data", 256'(out_data), 256'(h_d));
                chk("hold_idx", 256'(out_idx), 256'(h_ix));
                chk("hold_desc", 256'(out_desc), 256'(h_dsc));
            end
            in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) keys[k] = W'($urandom_range(0, 15) * 17 % 256);
            in_data   = keys;
            in_desc   = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            #1;
            chk("rnd_in_ready", 256'(in_ready), 256'(!(q.size() == 3 && !out_ready)));
            if (out_valid && out_ready) begin
                chk("rnd_not_extra", 256'(q.size() != 0), 256'(1));
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("rnd_data", 256'(out_data), 256'(e.d));
                    chk("rnd_idx", 256'(out_idx), 256'(e.ix));
                    chk("rnd_desc", 256'(out_desc), 256'(e.dsc));
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_sort(keys, in_desc));
                sent++;
            end
            stalled = out_valid && !out_ready;
            h_d = out_data; h_ix = out_idx; h_dsc = out_desc;
        end
        chk("rnd_all_sent", 256'(sent), 256'(100));
        chk("rnd_all_drained", 256'(q.size()), 256'(0));

        // Fill all three stages, then reset with everything in flight.
        @(negedge clk);
        out_ready = 1'b0;
        for (int v = 0; v < 3; v++) begin
            in_valid = 1'b1; in_data = {N{8'h3C}}; in_desc = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("full_in_ready", 256'(in_ready), 256'(0));
        chk("full_out_valid", 256'(out_valid), 256'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 256'(out_valid), 256'(0));
        chk("midrst_out_data", 256'(out_data), 256'(0));
        chk("midrst_in_ready", 256'(in_ready), 256'(1));
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("post_rst_no_stale", 256'(out_valid), 256'(0));
        end

        // Small configuration: N=4, W=3.
        for (int k = 0; k < NS; k++) skeys[k] = WS'(NS - 1 - k);
        for (int s = 0; s < NS; s++) begin
            sed[s*WS +: WS] = WS'(s); sei[s*IXS +: IXS] = IXS'(NS - 1 - s);
        end
        run_small(skeys, sed, sei, "small_rev");
        for (int k = 0; k < NS; k++) skeys[k] = (k % 2 == 0) ? WS'(5) : WS'(0);
        for (int s = 0; s < NS; s++) begin
            sed[s*WS +: WS]   = (s < 2) ? WS'(0) : WS'(5);
            sei[s*IXS +: IXS] = (s < 2) ? IXS'(2*s + 1) : IXS'(2*(s - 2));
        end
        run_small(skeys, sed, sei, "small_stable");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
